// File: rtl/proc_test_mem_responder_if.sv
// Request/response stream bundle between the processor-side master and the test memory responder.
// A beat transfers on any cycle where val and rdy are both 1; val never depends on rdy combinationally.
interface proc_test_mem_responder_if;
    logic        reqstream_val;
    logic        reqstream_rdy;
    logic [2:0]  reqstream_type;
    logic [7:0]  reqstream_opaque;
    logic [31:0] reqstream_addr;
    logic [1:0]  reqstream_len;
    logic [31:0] reqstream_data;

    logic        respstream_val;
    logic        respstream_rdy;
    logic [2:0]  respstream_type;
    logic [7:0]  respstream_opaque;
    logic [1:0]  respstream_test;
    logic [1:0]  respstream_len;
    logic [31:0] respstream_data;

    modport master (
        output reqstream_val, reqstream_type, reqstream_opaque, reqstream_addr,
               reqstream_len, reqstream_data, respstream_rdy,
        input  reqstream_rdy, respstream_val, respstream_type, respstream_opaque,
               respstream_test, respstream_len, respstream_data
    );

    modport slave (
        input  reqstream_val, reqstream_type, reqstream_opaque, reqstream_addr,
               reqstream_len, reqstream_data, respstream_rdy,
        output reqstream_rdy, respstream_val, respstream_type, respstream_opaque,
               respstream_test, respstream_len, respstream_data
    );
endinterface

// File: rtl/proc_test_mem_responder.sv
// Single-port test memory: one 4B read/write/init at a time, answered after p_latency idle cycles.
// The array access happens on the edge that enters RESP, so response data is always registered.
module proc_test_mem_responder #(
    parameter int p_mem_nbytes = 4096,
    parameter int p_latency    = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    proc_test_mem_responder_if.slave        bus,
    output logic [1:0]                      state_o
);
    localparam int AW = $clog2(p_mem_nbytes);
    localparam logic [3:0] LAT_M1 = (p_latency > 0) ? 4'(p_latency - 1) : 4'd0;
    localparam logic [2:0] TYPE_READ  = 3'd0;
    localparam logic [2:0] TYPE_WRITE = 3'd1;
    localparam logic [2:0] TYPE_INIT  = 3'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;

    logic [2:0]    lat_type_q;
    logic [7:0]    lat_opaque_q;
    logic [AW-1:0] lat_addr_q;
    logic [1:0]    lat_len_q;
    logic [31:0]   lat_data_q;

    logic [2:0]    resp_type_q;
    logic [7:0]    resp_opaque_q;
    logic [1:0]    resp_len_q;
    logic [31:0]   resp_data_q;

    logic          req_rdy;
    logic          resp_val;
    logic          req_fire;
    logic          access_en;
    logic          use_latched;
    logic          wr_en;

    logic [2:0]    acc_type;
    logic [7:0]    acc_opaque;
    logic [AW-1:0] acc_addr;
    logic [1:0]    acc_len;
    logic [31:0]   acc_data;
    logic [2:0]    acc_nbytes;
    logic [3:0]    acc_be;
    logic [AW-1:0] acc_idx [4];
    logic [31:0]   rd_data;

    logic [7:0]    mem [p_mem_nbytes];

    // Address bits above the array size alias onto the same bytes.
    logic          unused_addr_hi;
    assign unused_addr_hi = ^bus.reqstream_addr[31:AW];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_rdy     = 1'b0;
        resp_val    = 1'b0;
        access_en   = 1'b0;
        use_latched = 1'b0;
        case (state_q)
            IDLE: begin
                req_rdy = 1'b1;
                if (bus.reqstream_val) begin
                    if (p_latency == 0) begin
                        state_d   = RESP;
                        access_en = 1'b1;
                    end else begin
                        state_d = DELAY;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            DELAY: begin
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    access_en   = 1'b1;
                    use_latched = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                resp_val = 1'b1;
                if (bus.respstream_rdy) begin
                    if (p_latency == 0) begin
                        // Zero-latency mode chains a new request behind the departing response.
                        req_rdy = 1'b1;
                        if (bus.reqstream_val) begin
                            access_en = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_fire = bus.reqstream_val && req_rdy;

    always_comb begin
        acc_type   = use_latched ? lat_type_q   : bus.reqstream_type;
        acc_opaque = use_latched ? lat_opaque_q : bus.reqstream_opaque;
        acc_addr   = use_latched ? lat_addr_q   : bus.reqstream_addr[AW-1:0];
        acc_len    = use_latched ? lat_len_q    : bus.reqstream_len;
        acc_data   = use_latched ? lat_data_q   : bus.reqstream_data;
        acc_nbytes = (acc_len == 2'd0) ? 3'd4 : {1'b0, acc_len};
        rd_data    = '0;
        acc_be     = '0;
        for (int i = 0; i < 4; i++) begin
            acc_idx[i] = acc_addr + AW'(i);
            if (i < int'(acc_nbytes)) begin
                acc_be[i] = 1'b1;
                if (acc_type == TYPE_READ) begin
                    rd_data[8*i +: 8] = mem[acc_idx[i]];
                end
            end
        end
    end

    assign wr_en = access_en && !reset &&
                   ((acc_type == TYPE_WRITE) || (acc_type == TYPE_INIT));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx[i]] <= acc_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            lat_type_q    <= '0;
            lat_opaque_q  <= '0;
            lat_addr_q    <= '0;
            lat_len_q     <= '0;
            lat_data_q    <= '0;
            resp_type_q   <= '0;
            resp_opaque_q <= '0;
            resp_len_q    <= '0;
            resp_data_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (req_fire) begin
                lat_type_q   <= bus.reqstream_type;
                lat_opaque_q <= bus.reqstream_opaque;
                lat_addr_q   <= bus.reqstream_addr[AW-1:0];
                lat_len_q    <= bus.reqstream_len;
                lat_data_q   <= bus.reqstream_data;
            end
            if (access_en) begin
                resp_type_q   <= acc_type;
                resp_opaque_q <= acc_opaque;
                resp_len_q    <= acc_len;
                resp_data_q   <= rd_data;
            end
        end
    end

    assign bus.reqstream_rdy     = req_rdy;
    assign bus.respstream_val    = resp_val;
    assign bus.respstream_type   = resp_type_q;
    assign bus.respstream_opaque = resp_opaque_q;
    assign bus.respstream_test   = 2'b00;
    assign bus.respstream_len    = resp_len_q;
    assign bus.respstream_data   = resp_data_q;
    assign state_o               = state_q;
endmodule

// File: tb/tb_proc_test_mem_responder.sv
// Directed bench: a zero-latency and a three-cycle-latency responder side by side on one clock/reset.
module tb_proc_test_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  state0, state3;
    logic [16:0] ctl0, ctl3;
    int          checks = 0;
    int          errors = 0;

    proc_test_mem_responder_if bus0 ();
    proc_test_mem_responder_if bus3 ();

    proc_test_mem_responder #(.p_mem_nbytes(4096), .p_latency(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .state_o(state0)
    );
    proc_test_mem_responder #(.p_mem_nbytes(4096), .p_latency(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3), .state_o(state3)
    );

    always #5 clk = ~clk;

    assign ctl0 = {bus0.reqstream_rdy, bus0.respstream_val, bus0.respstream_type,
                   bus0.respstream_opaque, bus0.respstream_test, bus0.respstream_len};
    assign ctl3 = {bus3.reqstream_rdy, bus3.respstream_val, bus3.respstream_type,
                   bus3.respstream_opaque, bus3.respstream_test, bus3.respstream_len};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive0(input logic [2:0] t, input logic [7:0] o, input logic [31:0] a,
                          input logic [1:0] l, input logic [31:0] d);
        bus0.reqstream_val    = 1'b1;
        bus0.reqstream_type   = t;
        bus0.reqstream_opaque = o;
        bus0.reqstream_addr   = a;
        bus0.reqstream_len    = l;
        bus0.reqstream_data   = d;
        @(negedge clk);
    endtask

    task automatic idle0();
        bus0.reqstream_val = 1'b0;
        @(negedge clk);
        check("idle0_val", bus0.respstream_val, 1'b0);
    endtask

    task automatic expect0(input string tag, input logic [2:0] t, input logic [7:0] o,
                           input logic [1:0] l, input logic [31:0] d);
        check({tag, "_val"}, bus0.respstream_val, 1'b1);
        check({tag, "_hdr"}, {bus0.respstream_type, bus0.respstream_opaque,
                              bus0.respstream_test, bus0.respstream_len}, {t, o, 2'b00, l});
        check({tag, "_data"}, bus0.respstream_data, d);
    endtask

    task automatic req3(input string tag, input logic [2:0] t, input logic [7:0] o,
                        input logic [31:0] a, input logic [1:0] l, input logic [31:0] d,
                        input logic [31:0] exp_d);
        int n;
        bus3.reqstream_val    = 1'b1;
        bus3.reqstream_type   = t;
        bus3.reqstream_opaque = o;
        bus3.reqstream_addr   = a;
        bus3.reqstream_len    = l;
        bus3.reqstream_data   = d;
        bus3.respstream_rdy   = 1'b1;
        @(negedge clk);
        bus3.reqstream_val = 1'b0;
        n = 0;
        while (!bus3.respstream_val && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, 3);
        check({tag, "_hdr"}, {bus3.respstream_type, bus3.respstream_opaque,
                              bus3.respstream_test, bus3.respstream_len}, {t, o, 2'b00, l});
        check({tag, "_data"}, bus3.respstream_data, exp_d);
        @(negedge clk);
        check({tag, "_done"}, bus3.respstream_val, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        bus0.reqstream_val = 1'b0; bus0.reqstream_type = '0; bus0.reqstream_opaque = '0;
        bus0.reqstream_addr = '0; bus0.reqstream_len = '0; bus0.reqstream_data = '0;
        bus0.respstream_rdy = 1'b1;
        bus3.reqstream_val = 1'b0; bus3.reqstream_type = '0; bus3.reqstream_opaque = '0;
        bus3.reqstream_addr = '0; bus3.reqstream_len = '0; bus3.reqstream_data = '0;
        bus3.respstream_rdy = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst_ctl0", ctl0, 32'h10000);
            check("rst_data0", bus0.respstream_data, 32'h0);
            check("rst_ctl3", ctl3, 32'h10000);
            check("rst_data3", bus3.respstream_data, 32'h0);
        end
        check("rst_state0", state0, 2'd0);
        check("rst_state3", state3, 2'd0);

        // Back-to-back init then read at full throughput.
        drive0(3'd2, 8'h11, 32'h1000, 2'd0, 32'hdeadbeef);
        expect0("init", 3'd2, 8'h11, 2'd0, 32'h0);
        check("init_reqrdy", bus0.reqstream_rdy, 1'b1);
        drive0(3'd0, 8'h12, 32'h1000, 2'd0, 32'h0);
        expect0("rd_init", 3'd0, 8'h12, 2'd0, 32'hdeadbeef);

        drive0(3'd1, 8'h13, 32'h1000, 2'd0, 32'h11223344);
        expect0("wr_word", 3'd1, 8'h13, 2'd0, 32'h0);
        drive0(3'd1, 8'h14, 32'h1001, 2'd1, 32'h000000aa);
        expect0("wr_byte", 3'd1, 8'h14, 2'd1, 32'h0);
        drive0(3'd0, 8'h15, 32'h1000, 2'd0, 32'h0);
        expect0("rd_word", 3'd0, 8'h15, 2'd0, 32'h1122aa44);
        drive0(3'd0, 8'h16, 32'h1002, 2'd2, 32'h0);
        expect0("rd_half", 3'd0, 8'h16, 2'd2, 32'h00001122);

        drive0(3'd5, 8'h18, 32'h1000, 2'd0, 32'h55555555);
        expect0("resv", 3'd5, 8'h18, 2'd0, 32'h0);
        drive0(3'd0, 8'h19, 32'h1000, 2'd0, 32'h0);
        expect0("resv_rd", 3'd0, 8'h19, 2'd0, 32'h1122aa44);
        idle0();

        // Stalled consumer: the response holds and a waiting request is refused.
        bus0.respstream_rdy = 1'b0;
        drive0(3'd0, 8'h1b, 32'h1000, 2'd0, 32'h0);
        expect0("bp0_rd", 3'd0, 8'h1b, 2'd0, 32'h1122aa44);
        drive0(3'd0, 8'h1a, 32'h1002, 2'd2, 32'h0);
        check("bp0_rdy", bus0.reqstream_rdy, 1'b0);
        expect0("bp0_hold", 3'd0, 8'h1b, 2'd0, 32'h1122aa44);
        bus0.respstream_rdy = 1'b1;
        @(negedge clk);
        expect0("bp0_next", 3'd0, 8'h1a, 2'd2, 32'h00001122);
        idle0();

        drive0(3'd1, 8'h17, 32'h0ffe, 2'd0, 32'h01020304);
        expect0("wrap_wr", 3'd1, 8'h17, 2'd0, 32'h0);
        drive0(3'd0, 8'h20, 32'h0ffe, 2'd1, 32'h0);
        expect0("wrap_b0", 3'd0, 8'h20, 2'd1, 32'h04);
        drive0(3'd0, 8'h21, 32'h0fff, 2'd1, 32'h0);
        expect0("wrap_b1", 3'd0, 8'h21, 2'd1, 32'h03);
        drive0(3'd0, 8'h22, 32'h0000, 2'd1, 32'h0);
        expect0("wrap_b2", 3'd0, 8'h22, 2'd1, 32'h02);
        drive0(3'd0, 8'h23, 32'h0001, 2'd1, 32'h0);
        expect0("wrap_b3", 3'd0, 8'h23, 2'd1, 32'h01);
        drive0(3'd0, 8'h24, 32'h0ffe, 2'd0, 32'h0);
        expect0("wrap_rd", 3'd0, 8'h24, 2'd0, 32'h01020304);
        idle0();

        req3("w3", 3'd1, 8'h21, 32'h20, 2'd0, 32'hcafef00d, 32'h0);
        req3("r3", 3'd0, 8'h22, 32'h20, 2'd0, 32'h0, 32'hcafef00d);

        // Latency 3 with the consumer stalled well past the response.
        bus3.reqstream_val = 1'b1; bus3.reqstream_type = 3'd0; bus3.reqstream_opaque = 8'h23;
        bus3.reqstream_addr = 32'h20; bus3.reqstream_len = 2'd0; bus3.respstream_rdy = 1'b0;
        check("bp3_rdy_idle", bus3.reqstream_rdy, 1'b1);
        @(negedge clk);
        bus3.reqstream_val = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            check("bp3_reqrdy", bus3.reqstream_rdy, 1'b0);
            check("bp3_val", bus3.respstream_val, (k >= 4) ? 1'b1 : 1'b0);
            if (k == 2) check("bp3_state", state3, 2'd1);
            if (k >= 4) begin
                check("bp3_hdr", ctl3, {1'b0, 1'b1, 3'd0, 8'h23, 2'b00, 2'd0});
                check("bp3_data", bus3.respstream_data, 32'hcafef00d);
            end
            if (k == 9) bus3.respstream_rdy = 1'b1;
            @(negedge clk);
        end
        check("bp3_done_val", bus3.respstream_val, 1'b0);
        check("bp3_done_rdy", bus3.reqstream_rdy, 1'b1);

        // Reset during DELAY drops the pending write and its response.
        req3("pre", 3'd1, 8'h30, 32'h40, 2'd0, 32'haaaaaaaa, 32'h0);
        bus3.reqstream_val = 1'b1; bus3.reqstream_type = 3'd1; bus3.reqstream_opaque = 8'h31;
        bus3.reqstream_addr = 32'h40; bus3.reqstream_len = 2'd0; bus3.reqstream_data = 32'h12345678;
        bus3.respstream_rdy = 1'b1;
        @(negedge clk);
        bus3.reqstream_val = 1'b0;
        check("rst_mid_delay", state3, 2'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_state", state3, 2'd0);
        check("rst_mid_ctl", ctl3, 32'h10000);
        check("rst_mid_data", bus3.respstream_data, 32'h0);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus3.respstream_val) n++;
        end
        check("rst_mid_noresp", n, 0);
        req3("post", 3'd0, 8'h32, 32'h40, 2'd0, 32'h0, 32'haaaaaaaa);

        drive0(3'd0, 8'h40, 32'h1000, 2'd0, 32'h0);
        expect0("rst_keep0", 3'd0, 8'h40, 2'd0, 32'h11220102);
        idle0();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
